// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: well-known register numbers, writeback select
// encoding and the MEM/WB field bundle also consumed by the forwarding unit.
package pipe_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

  typedef enum logic [1:0] {
    WB_SEL_ALU  = 2'd0,
    WB_SEL_MEM  = 2'd1,
    WB_SEL_LINK = 2'd2
  } wbSel_e;

  typedef struct packed {
    logic        valid;
    logic        regWrite;
    logic        memToReg;
    logic        link;
    logic [4:0]  writeRegister;
    logic [31:0] aluResult;
    logic [31:0] readData;
    logic [31:0] pcPlus4;
  } memWbFields_t;

  // Link outranks the load path, which outranks the ALU result.
  function automatic wbSel_e wbSelFor(input logic link, input logic memToReg);
    if (link) begin
      return WB_SEL_LINK;
    end else if (memToReg) begin
      return WB_SEL_MEM;
    end
    return WB_SEL_ALU;
  endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM/WB boundary bundle: memory-stage results and hazard controls in,
// register-file write port and WB valid out.
interface mem_wb_stage_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
);
  logic              stall;
  logic              flush;
  logic              m_valid;
  logic              m_RegWrite;
  logic              m_MemtoReg;
  logic              m_Link;
  logic [REG_AW-1:0] m_WriteRegister;
  logic [DATA_W-1:0] m_ALUResult;
  logic [DATA_W-1:0] m_ReadData;
  logic [DATA_W-1:0] m_PCPlus4;

  logic              RegWrite;
  logic [REG_AW-1:0] WriteRegister;
  logic [DATA_W-1:0] WriteData;
  logic              wb_valid;

  modport master (
    output stall, flush, m_valid, m_RegWrite, m_MemtoReg, m_Link,
    output m_WriteRegister, m_ALUResult, m_ReadData, m_PCPlus4,
    input  RegWrite, WriteRegister, WriteData, wb_valid
  );

  modport slave (
    input  stall, flush, m_valid, m_RegWrite, m_MemtoReg, m_Link,
    input  m_WriteRegister, m_ALUResult, m_ReadData, m_PCPlus4,
    output RegWrite, WriteRegister, WriteData, wb_valid
  );
endinterface

// File: rtl/wb_mux.sv
// Writeback data select: PC+4 for links, load data for loads, else ALU result.
module wb_mux
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              link,
  input  logic              memToReg,
  input  logic [DATA_W-1:0] aluResult,
  input  logic [DATA_W-1:0] readData,
  input  logic [DATA_W-1:0] pcPlus4,
  output logic [DATA_W-1:0] writeData
);

  wbSel_e sel;
  assign sel = wbSelFor(link, memToReg);

  always_comb begin
    writeData = aluResult;
    unique case (sel)
      WB_SEL_LINK: writeData = pcPlus4;
      WB_SEL_MEM:  writeData = readData;
      default:     writeData = aluResult;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with $zero write suppression and jal $ra forcing.
// Optional retired-instruction counter enabled by MEM_WB_RETIRE_CNT_EN.
module mem_wb_stage
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef MEM_WB_RETIRE_CNT_EN
  input  logic         cnt_clr,
  output logic [31:0]  retired_cnt,
`endif
  mem_wb_stage_if.slave bus
);

  logic              validQ;
  logic              regWriteQ;
  logic              memToRegQ;
  logic              linkQ;
  logic [REG_AW-1:0] writeRegisterQ;
  logic [DATA_W-1:0] aluResultQ;
  logic [DATA_W-1:0] readDataQ;
  logic [DATA_W-1:0] pcPlus4Q;
  logic              loadFire;

  assign loadFire = !bus.flush && !bus.stall;

  // Flush only kills valid/RegWrite; data fields keep their last values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      validQ         <= 1'b0;
      regWriteQ      <= 1'b0;
      memToRegQ      <= 1'b0;
      linkQ          <= 1'b0;
      writeRegisterQ <= '0;
      aluResultQ     <= '0;
      readDataQ      <= '0;
      pcPlus4Q       <= '0;
    end else if (bus.flush) begin
      validQ    <= 1'b0;
      regWriteQ <= 1'b0;
    end else if (loadFire) begin
      validQ         <= bus.m_valid;
      regWriteQ      <= bus.m_RegWrite | bus.m_Link;
      memToRegQ      <= bus.m_MemtoReg;
      linkQ          <= bus.m_Link;
      writeRegisterQ <= bus.m_Link ? REG_AW'(REG_RA) : bus.m_WriteRegister;
      aluResultQ     <= bus.m_ALUResult;
      readDataQ      <= bus.m_ReadData;
      pcPlus4Q       <= bus.m_PCPlus4;
    end
  end

  assign bus.wb_valid      = validQ;
  assign bus.WriteRegister = writeRegisterQ;
  assign bus.RegWrite      = validQ & regWriteQ & (writeRegisterQ != REG_AW'(REG_ZERO));

  wb_mux #(
    .DATA_W (DATA_W)
  ) u_wb_mux (
    .link      (linkQ),
    .memToReg  (memToRegQ),
    .aluResult (aluResultQ),
    .readData  (readDataQ),
    .pcPlus4   (pcPlus4Q),
    .writeData (bus.WriteData)
  );

`ifdef MEM_WB_RETIRE_CNT_EN
  logic [31:0] retiredCntQ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retiredCntQ <= '0;
    end else if (cnt_clr) begin
      retiredCntQ <= '0;
    end else if (loadFire && bus.m_valid) begin
      retiredCntQ <= retiredCntQ + 32'd1;
    end
  end

  assign retired_cnt = retiredCntQ;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomised bench for mem_wb_stage against a field-level model of the MEM/WB
// entry plus a shadow register file that commits on the falling edge.
module tb_mem_wb_stage;
  import pipe_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
`ifdef MEM_WB_RETIRE_CNT_EN
  logic        cnt_clr = 1'b0;
  logic [31:0] retired_cnt;
  logic [31:0] expCnt = '0;
`endif

  mem_wb_stage_if #(.DATA_W(DW), .REG_AW(AW)) bus ();

  mem_wb_stage #(
    .DATA_W (DW),
    .REG_AW (AW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef MEM_WB_RETIRE_CNT_EN
    .cnt_clr     (cnt_clr),
    .retired_cnt (retired_cnt),
`endif
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  memWbFields_t model = '0;
  logic [31:0] dutRf   [32];
  logic [31:0] modelRf [32];

  function automatic logic expWrite(input memWbFields_t e);
    return e.valid && e.regWrite && (e.writeRegister != 5'd0);
  endfunction

  function automatic logic [31:0] expData(input memWbFields_t e);
    if (e.link) return e.pcPlus4;
    if (e.memToReg) return e.readData;
    return e.aluResult;
  endfunction

  // Register file driven by the DUT, and its reference twin driven by the model.
  always @(negedge clk) begin
    if (bus.RegWrite) dutRf[bus.WriteRegister] <= bus.WriteData;
    if (expWrite(model)) modelRf[model.writeRegister] <= expData(model);
  end

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic setIn(input logic v, input logic rw, input logic mtr, input logic lk,
                       input logic [4:0] d, input logic [31:0] a, input logic [31:0] r,
                       input logic [31:0] p);
    bus.m_valid         = v;
    bus.m_RegWrite      = rw;
    bus.m_MemtoReg      = mtr;
    bus.m_Link          = lk;
    bus.m_WriteRegister = d;
    bus.m_ALUResult     = a;
    bus.m_ReadData      = r;
    bus.m_PCPlus4       = p;
  endtask

  task automatic checkOut(input string tag);
    checkEq({tag, ".wb_valid"}, 64'(bus.wb_valid), 64'(model.valid));
    checkEq({tag, ".RegWrite"}, 64'(bus.RegWrite), 64'(expWrite(model)));
    if (model.valid) begin
      checkEq({tag, ".WriteRegister"}, 64'(bus.WriteRegister), 64'(model.writeRegister));
      checkEq({tag, ".WriteData"}, 64'(bus.WriteData), 64'(expData(model)));
    end
`ifdef MEM_WB_RETIRE_CNT_EN
    checkEq({tag, ".retired_cnt"}, 64'(retired_cnt), 64'(expCnt));
`endif
  endtask

  // One clock: apply stall/flush to the current inputs, advance the model, compare.
  task automatic step(input string tag, input logic st, input logic fl);
    memWbFields_t nxt;
    bus.stall = st;
    bus.flush = fl;
    nxt = model;
    if (fl) begin
      nxt.valid    = 1'b0;
      nxt.regWrite = 1'b0;
    end else if (!st) begin
      nxt.valid         = bus.m_valid;
      nxt.regWrite      = bus.m_RegWrite || bus.m_Link;
      nxt.memToReg      = bus.m_MemtoReg;
      nxt.link          = bus.m_Link;
      nxt.writeRegister = bus.m_Link ? 5'd31 : bus.m_WriteRegister;
      nxt.aluResult     = bus.m_ALUResult;
      nxt.readData      = bus.m_ReadData;
      nxt.pcPlus4       = bus.m_PCPlus4;
    end
`ifdef MEM_WB_RETIRE_CNT_EN
    if (cnt_clr) expCnt = '0;
    else if (!fl && !st && bus.m_valid) expCnt = expCnt + 32'd1;
`endif
    @(posedge clk);
    #1;
    model = nxt;
    checkOut(tag);
  endtask

  // Asynchronous reset pulse between edges; outputs must clear before any clock.
  task automatic midReset(input string tag);
    rst_n = 1'b0;
    #1;
    checkEq({tag, ".RegWrite"}, 64'(bus.RegWrite), 64'd0);
    checkEq({tag, ".WriteData"}, 64'(bus.WriteData), 64'd0);
    checkEq({tag, ".wb_valid"}, 64'(bus.wb_valid), 64'd0);
    model = '0;
`ifdef MEM_WB_RETIRE_CNT_EN
    expCnt = '0;
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      dutRf[i]   = '0;
      modelRf[i] = '0;
    end
    setIn(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, '0, '0, '0);
    bus.stall = 1'b0;
    bus.flush = 1'b0;

    #2 rst_n = 1'b0;
    #1;
    checkEq("reset.RegWrite", 64'(bus.RegWrite), 64'd0);
    checkEq("reset.WriteRegister", 64'(bus.WriteRegister), 64'd0);
    checkEq("reset.WriteData", 64'(bus.WriteData), 64'd0);
    checkEq("reset.wb_valid", 64'(bus.wb_valid), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    setIn(1'b1, 1'b1, 1'b0, 1'b0, 5'd8, 32'h0000_1234, 32'h5555_5555, 32'h0040_0000);
    step("alu", 1'b0, 1'b0);
    checkEq("alu.WriteData", 64'(bus.WriteData), 64'h1234);
    @(negedge clk);
    #1 checkEq("alu.rf8", 64'(dutRf[8]), 64'h1234);

    setIn(1'b1, 1'b1, 1'b1, 1'b0, 5'd16, 32'h1111_1111, 32'hDEAD_BEEF, 32'h0040_0004);
    step("load", 1'b0, 1'b0);
    checkEq("load.WriteData", 64'(bus.WriteData), 64'hDEAD_BEEF);
    setIn(1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h1111_1111, 32'hDEAD_BEEF, 32'h0040_0008);
    step("zero", 1'b0, 1'b0);
    checkEq("zero.RegWrite", 64'(bus.RegWrite), 64'd0);
    @(negedge clk);
    #1 checkEq("zero.rf0", 64'(dutRf[0]), 64'd0);

    setIn(1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 32'h2222_2222, 32'h3333_3333, 32'h0040_0010);
    step("jal", 1'b0, 1'b0);
    checkEq("jal.WriteRegister", 64'(bus.WriteRegister), 64'd31);
    checkEq("jal.WriteData", 64'(bus.WriteData), 64'h0040_0010);
    checkEq("jal.RegWrite", 64'(bus.RegWrite), 64'd1);

    setIn(1'b1, 1'b1, 1'b0, 1'b0, 5'd9, 32'h0000_A5A5, 32'h0, 32'h0040_0014);
    step("hold0", 1'b0, 1'b0);
    setIn(1'b1, 1'b1, 1'b0, 1'b0, 5'd10, 32'h0000_7777, 32'h0, 32'h0040_0018);
    step("hold1", 1'b1, 1'b0);
    step("hold2", 1'b1, 1'b0);
    checkEq("hold.WriteData", 64'(bus.WriteData), 64'hA5A5);
    step("stallflush", 1'b1, 1'b1);
    checkEq("stallflush.wb_valid", 64'(bus.wb_valid), 64'd0);

    setIn(1'b1, 1'b1, 1'b0, 1'b0, 5'd8, 32'h0000_CAFE, 32'h0, 32'h0040_001C);
    step("prereset", 1'b0, 1'b0);
    midReset("midreset");
    checkEq("midreset.rf8", 64'(dutRf[8]), 64'h1234);
    setIn(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, '0, '0, '0);
    step("postreset", 1'b0, 1'b0);

`ifdef MEM_WB_RETIRE_CNT_EN
    cnt_clr = 1'b1;
    step("cntclr0", 1'b0, 1'b0);
    cnt_clr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      setIn(1'b1, 1'b1, 1'b0, 1'b0, 5'(i + 1), 32'(i), '0, '0);
      step("cnt", (i == 5) || (i == 6), i == 2);
    end
    checkEq("cnt.five", 64'(retired_cnt), 64'd5);
    cnt_clr = 1'b1;
    step("cntclr1", 1'b0, 1'b0);
    checkEq("cntclr1.zero", 64'(retired_cnt), 64'd0);
    cnt_clr = 1'b0;
`endif

    for (int n = 0; n < 400; n++) begin
      setIn(1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), $urandom, $urandom, $urandom);
`ifdef MEM_WB_RETIRE_CNT_EN
      cnt_clr = ($urandom_range(0, 30) == 0);
`endif
      step("rand", ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 99) == 0) midReset("randreset");
    end
`ifdef MEM_WB_RETIRE_CNT_EN
    cnt_clr = 1'b0;
`endif

    @(negedge clk);
    #1;
    for (int i = 0; i < 32; i++) checkEq("regfile", 64'(dutRf[i]), 64'(modelRf[i]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
